stage_mem_lsu: RTL and testbench
================================

STAGE_MEM_LSU -- requirements
Module: stage_mem_lsu

Interface
REQ-001 Parameter RW, default 5: register-address width of waddr/waddr_o.
REQ-002 Parameter TIMEOUT, default 15, range 1..255: maximum WAIT-state cycles before a memory access is abandoned.
REQ-003 Data and address paths SHALL be fixed at 32 bits.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 in_valid  in  1  upstream (EX) presents an instruction.
REQ-007 in_ready  out  1  stage accepts; equals 1 exactly when state==IDLE and rst==0.
REQ-008 we / waddr / wdata  in  1 / RW / 32  register write enable, destination, ALU result (effective address for memory ops).
REQ-009 mem_op  in  4  0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 8 SB, 9 SH, 10 SW; all other codes SHALL be treated as NONE.
REQ-010 store_data  in  32  store source operand.
REQ-011 out_valid / we_o / waddr_o / wdata_o  out  1 / 1 / RW / 32  registered writeback result, valid for one cycle.
REQ-012 exc_misalign / exc_timeout  out  1 / 1  one-cycle exception flags, asserted only together with out_valid.
REQ-013 dmem_req / dmem_wr / dmem_addr / dmem_wdata / dmem_be  out  1 / 1 / 32 / 32 / 4  data-memory request, all registered.
REQ-014 dmem_ack / dmem_rdata  in  1 / 32  memory completion and little-endian read word; sampled only while dmem_req==1.

Function
REQ-015 States SHALL be IDLE and WAIT only.
REQ-016 Accept SHALL occur on an edge where in_valid && in_ready.
REQ-017 NONE accepted at edge T: next cycle out_valid=1, we_o=we, waddr_o=waddr, wdata_o=wdata; state stays IDLE.
REQ-018 Cycles with no accept SHALL leave out_valid=0, both exc flags 0, and we_o=0.
REQ-019 Alignment rule: LH/LHU/SH require addr[0]==0; LW/SW require addr[1:0]==0.
REQ-020 Misaligned op accepted: no request issued; next cycle out_valid=1, exc_misalign=1, we_o=0, waddr_o=waddr.
REQ-021 Aligned memory op accepted at edge T: from T+1, state=WAIT, dmem_req=1, dmem_addr={addr[31:2],2'b00}, dmem_wr=1 for stores and 0 for loads.
REQ-022 Store lane enables dmem_be: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111; loads 4'b1111.
REQ-023 Store data dmem_wdata: SB {4{sd[7:0]}}; SH {2{sd[15:0]}}; SW sd.
REQ-024 All dmem_* outputs SHALL hold stable for the whole of WAIT.
REQ-025 Ack completion: dmem_ack==1 in WAIT cycle K SHALL give, in cycle K+1, dmem_req=0, state=IDLE, in_ready=1, out_valid=1.
REQ-026 Load result: byte/half selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word; we_o=we.
REQ-027 Store result: we_o=0 and wdata_o=0.
REQ-028 Timeout counting: WAIT cycles SHALL be counted from 1, counter width $clog2(TIMEOUT+1).
REQ-029 Timeout: no ack by the TIMEOUT-th WAIT cycle SHALL give, next cycle, dmem_req=0, IDLE, out_valid=1, exc_timeout=1, we_o=0.
REQ-030 Ack arriving in the TIMEOUT-th WAIT cycle SHALL complete normally; ack wins over timeout.
REQ-031 dmem_ack while dmem_req==0 SHALL be ignored.
REQ-032 No new instruction SHALL be accepted in WAIT; upstream holds via in_ready=0.

Reset
REQ-033 rst at an edge SHALL clear, from the next cycle: state=IDLE, counter=0, and every output to 0 except in_ready=1 (once rst deasserts).
REQ-034 rst during WAIT SHALL drop dmem_req next cycle, discard the pending op, and produce no out_valid.
REQ-035 A late ack after reset SHALL have no effect.

Verification
REQ-036 NONE, we=1, waddr=7, wdata=0x1234 -> next cycle out_valid=1, we_o=1, waddr_o=7, wdata_o=0x1234.
REQ-037 LB addr=0x103, rdata=0x80FF_0000, ack after 2 WAIT cycles -> dmem_addr=0x100, wdata_o=0xFFFF_FF80; LBU same stimulus -> 0x0000_0080.
REQ-038 SH addr=0x202, store_data=0xDEAD_BEEF -> dmem_wr=1, dmem_be=4'b1100, dmem_wdata=0xBEEF_BEEF, out_valid with we_o=0.
REQ-039 LW addr=0x101 -> dmem_req never asserted, exc_misalign=1 for one cycle, we_o=0.
REQ-040 LW with TIMEOUT=15 and no ack -> dmem_req high exactly 15 cycles, then exc_timeout=1; ack in the 15th WAIT cycle instead -> normal load, exc_timeout=0.
REQ-041 rst in the 3rd WAIT cycle, ack one cycle later -> dmem_req=0 after reset, out_valid stays 0, in_ready=1.

Source files
------------

// File: rtl/stage_mem_lsu_if.sv
// Handshake and data-memory bundle for the MEM stage. The slave side is the
// LSU itself; the master side is everything around it (EX stage, writeback
// consumer and data memory).
interface stage_mem_lsu_if #(
    parameter int RW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic          we;
    logic [RW-1:0] waddr;
    logic [31:0]   wdata;
    logic [3:0]    mem_op;
    logic [31:0]   store_data;

    logic          out_valid;
    logic          we_o;
    logic [RW-1:0] waddr_o;
    logic [31:0]   wdata_o;
    logic          exc_misalign;
    logic          exc_timeout;

    logic          dmem_req;
    logic          dmem_wr;
    logic [31:0]   dmem_addr;
    logic [31:0]   dmem_wdata;
    logic [3:0]    dmem_be;
    logic          dmem_ack;
    logic [31:0]   dmem_rdata;

    modport master (
        output in_valid, we, waddr, wdata, mem_op, store_data, dmem_ack, dmem_rdata,
        input  in_ready, out_valid, we_o, waddr_o, wdata_o, exc_misalign, exc_timeout,
        input  dmem_req, dmem_wr, dmem_addr, dmem_wdata, dmem_be
    );

    modport slave (
        input  in_valid, we, waddr, wdata, mem_op, store_data, dmem_ack, dmem_rdata,
        output in_ready, out_valid, we_o, waddr_o, wdata_o, exc_misalign, exc_timeout,
        output dmem_req, dmem_wr, dmem_addr, dmem_wdata, dmem_be
    );
endinterface

// File: rtl/stage_mem_lsu.sv
// MEM pipeline stage: passes non-memory results through in one cycle, and for
// loads/stores issues a single registered data-memory request, waits for ack
// (bounded by TIMEOUT cycles), then formats the writeback result.
module stage_mem_lsu #(
    parameter int RW      = 5,
    parameter int TIMEOUT = 15
) (
    input logic            clk,
    input logic            rst,
    stage_mem_lsu_if.slave bus
);
    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_TO  = CW'(TIMEOUT);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    // Every registered output of the stage; cleared as a unit on reset.
    typedef struct packed {
        logic          out_valid;
        logic          we_o;
        logic [RW-1:0] waddr_o;
        logic [31:0]   wdata_o;
        logic          exc_misalign;
        logic          exc_timeout;
        logic          dmem_req;
        logic          dmem_wr;
        logic [31:0]   dmem_addr;
        logic [31:0]   dmem_wdata;
        logic [3:0]    dmem_be;
    } out_t;

    // What is remembered about the in-flight memory op while waiting for ack.
    typedef struct packed {
        logic [3:0]    op;
        logic [1:0]    lane;
        logic          we;
        logic [RW-1:0] waddr;
    } ctx_t;

    function automatic logic op_is_load(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] lane);
        case (op)
            OP_LH, OP_LHU, OP_SH: return lane[0];
            OP_LW, OP_SW:         return |lane;
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_enables(input logic [3:0] op, input logic [1:0] lane);
        case (op)
            OP_SB:   return 4'b0001 << lane;
            OP_SH:   return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_word(input logic [3:0] op, input logic [31:0] sd);
        case (op)
            OP_SB:   return {4{sd[7:0]}};
            OP_SH:   return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] lane,
                                                 input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{lane, 3'b000} +: 8];
        h = lane[1] ? rd[31:16] : rd[15:0];
        case (op)
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'd0, b};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'd0, h};
            default: return rd;
        endcase
    endfunction

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    out_t          o_q, o_n;
    ctx_t          ctx_q, ctx_n;
    logic          ready;
    logic          ack;

    assign ready = (state == IDLE) && !rst;
    assign ack   = bus.dmem_ack && o_q.dmem_req;

    // State, wait counter, captured op and all outputs update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            o_q   <= '0;
            ctx_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            o_q   <= o_n;
            ctx_q <= ctx_n;
        end
    end

    // Next-state and next-output decode; result/exception pulses default low.
    always_comb begin
        state_n            = state;
        cnt_n              = cnt;
        ctx_n              = ctx_q;
        o_n                = o_q;
        o_n.out_valid      = 1'b0;
        o_n.we_o           = 1'b0;
        o_n.exc_misalign   = 1'b0;
        o_n.exc_timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid && ready) begin
                    if (!op_is_load(bus.mem_op) && !op_is_store(bus.mem_op)) begin
                        o_n.out_valid = 1'b1;
                        o_n.we_o      = bus.we;
                        o_n.waddr_o   = bus.waddr;
                        o_n.wdata_o   = bus.wdata;
                    end else if (op_misaligned(bus.mem_op, bus.wdata[1:0])) begin
                        o_n.out_valid    = 1'b1;
                        o_n.exc_misalign = 1'b1;
                        o_n.waddr_o      = bus.waddr;
                        o_n.wdata_o      = '0;
                    end else begin
                        state_n        = WAIT;
                        cnt_n          = CNT_ONE;
                        ctx_n.op       = bus.mem_op;
                        ctx_n.lane     = bus.wdata[1:0];
                        ctx_n.we       = bus.we;
                        ctx_n.waddr    = bus.waddr;
                        o_n.dmem_req   = 1'b1;
                        o_n.dmem_wr    = op_is_store(bus.mem_op);
                        o_n.dmem_addr  = {bus.wdata[31:2], 2'b00};
                        o_n.dmem_be    = lane_enables(bus.mem_op, bus.wdata[1:0]);
                        o_n.dmem_wdata = op_is_store(bus.mem_op) ?
                                         store_word(bus.mem_op, bus.store_data) : '0;
                    end
                end
            end
            WAIT: begin
                if (ack) begin
                    state_n       = IDLE;
                    cnt_n         = '0;
                    o_n.dmem_req  = 1'b0;
                    o_n.out_valid = 1'b1;
                    o_n.waddr_o   = ctx_q.waddr;
                    if (op_is_store(ctx_q.op)) begin
                        o_n.wdata_o = '0;
                    end else begin
                        o_n.we_o    = ctx_q.we;
                        o_n.wdata_o = load_extract(ctx_q.op, ctx_q.lane, bus.dmem_rdata);
                    end
                end else if (cnt == CNT_TO) begin
                    state_n         = IDLE;
                    cnt_n           = '0;
                    o_n.dmem_req    = 1'b0;
                    o_n.out_valid   = 1'b1;
                    o_n.exc_timeout = 1'b1;
                    o_n.waddr_o     = ctx_q.waddr;
                    o_n.wdata_o     = '0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.in_ready     = ready;
    assign bus.out_valid    = o_q.out_valid;
    assign bus.we_o         = o_q.we_o;
    assign bus.waddr_o      = o_q.waddr_o;
    assign bus.wdata_o      = o_q.wdata_o;
    assign bus.exc_misalign = o_q.exc_misalign;
    assign bus.exc_timeout  = o_q.exc_timeout;
    assign bus.dmem_req     = o_q.dmem_req;
    assign bus.dmem_wr      = o_q.dmem_wr;
    assign bus.dmem_addr    = o_q.dmem_addr;
    assign bus.dmem_wdata   = o_q.dmem_wdata;
    assign bus.dmem_be      = o_q.dmem_be;
endmodule

// File: tb/tb_stage_mem_lsu.sv
// Bench for stage_mem_lsu: directed scenarios plus randomized transactions
// checked against a behavioural model of the MEM stage.
module tb_stage_mem_lsu;
    localparam int RW      = 5;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stage_mem_lsu_if #(.RW(RW)) bus();
    stage_mem_lsu #(.RW(RW), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
    endtask

    // Access size in bytes, 0 for anything that is not a memory op.
    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd4, 4'd8: return 1;
            4'd2, 4'd5, 4'd9: return 2;
            4'd3, 4'd10:      return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * (addr % 4));
        case (op)
            4'd1: begin v = v & 32'hFF;   if (v >= 32'd128)   v = v + 32'hFFFF_FF00; end
            4'd2: begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v + 32'hFFFF_0000; end
            4'd4: v = v & 32'hFF;
            4'd5: v = v & 32'hFFFF;
            default: v = rd;
        endcase
        return v;
    endfunction

    task automatic idle_cycle(input logic stray_ack);
        bus.dmem_ack   = stray_ack;
        bus.dmem_rdata = $urandom;
        @(posedge clk); #1;
        bus.dmem_ack = 1'b0;
        chk("idle_out_valid", 32'(bus.out_valid), 0);
        chk("idle_we_o", 32'(bus.we_o), 0);
        chk("idle_exc_misalign", 32'(bus.exc_misalign), 0);
        chk("idle_exc_timeout", 32'(bus.exc_timeout), 0);
        chk("idle_dmem_req", 32'(bus.dmem_req), 0);
        chk("idle_in_ready", 32'(bus.in_ready), 1);
    endtask

    // One instruction from accept to result. ack_at is the 1-based WAIT cycle
    // in which memory acks; 0 or beyond TIMEOUT means no ack.
    task automatic do_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                          input logic we, input logic [RW-1:0] wa, input int ack_at,
                          input logic [31:0] rd, output logic [31:0] res_wdata,
                          output logic res_we, output int req_cycles);
        int          sz;
        logic        is_st;
        logic        acked;
        logic        done;
        logic [31:0] exp_be;
        logic [31:0] exp_wd;
        sz         = op_size(op);
        is_st      = (op == 4'd8) || (op == 4'd9) || (op == 4'd10);
        acked      = (ack_at >= 1) && (ack_at <= TIMEOUT);
        req_cycles = 0;
        chk("accept_ready", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1; bus.mem_op = op; bus.wdata = addr;
        bus.store_data = sd; bus.we = we; bus.waddr = wa;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.mem_op = 4'($urandom); bus.wdata = $urandom;
        bus.store_data = $urandom; bus.we = 1'($urandom); bus.waddr = RW'($urandom);
        if (sz == 0) begin
            chk("none_out_valid", 32'(bus.out_valid), 1);
            chk("none_we_o", 32'(bus.we_o), 32'(we));
            chk("none_waddr_o", 32'(bus.waddr_o), 32'(wa));
            chk("none_wdata_o", bus.wdata_o, addr);
            chk("none_exc", 32'({bus.exc_misalign, bus.exc_timeout}), 0);
            chk("none_dmem_req", 32'(bus.dmem_req), 0);
        end else if ((addr % sz) != 0) begin
            chk("mis_out_valid", 32'(bus.out_valid), 1);
            chk("mis_exc_misalign", 32'(bus.exc_misalign), 1);
            chk("mis_exc_timeout", 32'(bus.exc_timeout), 0);
            chk("mis_we_o", 32'(bus.we_o), 0);
            chk("mis_waddr_o", 32'(bus.waddr_o), 32'(wa));
            chk("mis_dmem_req", 32'(bus.dmem_req), 0);
            chk("mis_in_ready", 32'(bus.in_ready), 1);
        end else begin
            if (!is_st || sz == 4) exp_be = 32'hF;
            else if (sz == 1)      exp_be = 32'h1 << (addr % 4);
            else                   exp_be = 32'h3 << (addr % 4);
            if (sz == 1)      exp_wd = (sd & 32'hFF) * 32'h0101_0101;
            else if (sz == 2) exp_wd = (sd & 32'hFFFF) * 32'h0001_0001;
            else              exp_wd = sd;
            done = 1'b0;
            for (int k = 1; k <= TIMEOUT + 2 && !done; k++) begin
                chk("wait_dmem_req", 32'(bus.dmem_req), 1);
                chk("wait_in_ready", 32'(bus.in_ready), 0);
                chk("wait_out_valid", 32'(bus.out_valid), 0);
                chk("dmem_addr", bus.dmem_addr, addr & 32'hFFFF_FFFC);
                chk("dmem_wr", 32'(bus.dmem_wr), 32'(is_st));
                chk("dmem_be", 32'(bus.dmem_be), exp_be);
                if (is_st) chk("dmem_wdata", bus.dmem_wdata, exp_wd);
                req_cycles++;
                if (k == ack_at) begin bus.dmem_ack = 1'b1; bus.dmem_rdata = rd; end
                @(posedge clk); #1;
                bus.dmem_ack = 1'b0; bus.dmem_rdata = $urandom;
                if (bus.out_valid) done = 1'b1;
            end
            chk("completed_in_bound", 32'(done), 1);
            chk("req_cycles", 32'(req_cycles), acked ? 32'(ack_at) : 32'(TIMEOUT));
            chk("end_dmem_req", 32'(bus.dmem_req), 0);
            chk("end_in_ready", 32'(bus.in_ready), 1);
            chk("end_out_valid", 32'(bus.out_valid), 1);
            chk("end_exc_misalign", 32'(bus.exc_misalign), 0);
            chk("end_exc_timeout", 32'(bus.exc_timeout), 32'(!acked));
            if (!acked || is_st) begin
                chk("end_we_o", 32'(bus.we_o), 0);
                if (acked) chk("store_wdata_o", bus.wdata_o, 0);
            end else begin
                chk("load_we_o", 32'(bus.we_o), 32'(we));
                chk("load_waddr_o", 32'(bus.waddr_o), 32'(wa));
                chk("load_wdata_o", bus.wdata_o, ref_load(op, addr, rd));
            end
        end
        res_wdata = bus.wdata_o;
        res_we    = bus.we_o;
    endtask

    initial begin
        logic [31:0] w;
        logic        wo;
        int          rc;
        bus.in_valid = 0; bus.we = 0; bus.waddr = '0; bus.wdata = '0; bus.mem_op = '0;
        bus.store_data = '0; bus.dmem_ack = 0; bus.dmem_rdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_dmem_req", 32'(bus.dmem_req), 0);
        chk("rst_dmem_be", 32'(bus.dmem_be), 0);
        chk("rst_wdata_o", bus.wdata_o, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 1);

        // Pass-through
        do_txn(4'd0, 32'h1234, 32'h0, 1'b1, RW'(7), 0, 32'h0, w, wo, rc);
        chk("none_example_wdata", w, 32'h1234);
        chk("none_example_we", 32'(wo), 1);
        idle_cycle(1'b0);

        // Byte loads from the top lane
        do_txn(4'd1, 32'h103, 32'h0, 1'b1, RW'(3), 3, 32'h80FF_0000, w, wo, rc);
        chk("lb_example", w, 32'hFFFF_FF80);
        do_txn(4'd4, 32'h103, 32'h0, 1'b1, RW'(3), 3, 32'h80FF_0000, w, wo, rc);
        chk("lbu_example", w, 32'h0000_0080);

        // Upper-half store
        do_txn(4'd9, 32'h202, 32'hDEAD_BEEF, 1'b1, RW'(4), 2, 32'h0, w, wo, rc);
        chk("sh_example_we", 32'(wo), 0);
        chk("sh_example_wdata", w, 0);

        // Misaligned word load
        do_txn(4'd3, 32'h101, 32'h0, 1'b1, RW'(9), 1, 32'h0, w, wo, rc);
        idle_cycle(1'b1);

        // Timeout, then ack exactly on the last allowed cycle
        do_txn(4'd3, 32'h400, 32'h0, 1'b1, RW'(5), 0, 32'h0, w, wo, rc);
        chk("timeout_req_cycles", 32'(rc), 15);
        do_txn(4'd3, 32'h400, 32'h0, 1'b1, RW'(5), TIMEOUT, 32'hCAFE_F00D, w, wo, rc);
        chk("last_cycle_ack_wdata", w, 32'hCAFE_F00D);
        idle_cycle(1'b0);

        // Reset in the third WAIT cycle, ack arriving one cycle later
        bus.in_valid = 1'b1; bus.mem_op = 4'd3; bus.wdata = 32'h500; bus.we = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("rst_wait_req", 32'(bus.dmem_req), 1);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h1111_2222;
        #1;
        chk("rst_wait_dmem_req", 32'(bus.dmem_req), 0);
        chk("rst_wait_out_valid", 32'(bus.out_valid), 0);
        chk("rst_wait_in_ready", 32'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.dmem_ack = 1'b0;
        chk("late_ack_out_valid", 32'(bus.out_valid), 0);
        chk("late_ack_dmem_req", 32'(bus.dmem_req), 0);
        chk("late_ack_in_ready", 32'(bus.in_ready), 1);

        // Randomized transactions
        for (int i = 0; i < 250; i++) begin
            logic [3:0]  op;
            logic [31:0] addr;
            int          ack_at;
            op     = 4'($urandom_range(0, 15));
            addr   = $urandom;
            ack_at = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TIMEOUT + 2));
            do_txn(op, addr, $urandom, 1'($urandom), RW'($urandom), ack_at, $urandom, w, wo, rc);
            if ($urandom_range(0, 2) == 0) idle_cycle(1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
